// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared memory command port between the GBA cart bus and the USB bridge.
// Define MEM_ARB_STARVE_GUARD_EN to bound how long USB can be starved by GBA priority.
//
// state    | meaning
// ST_IDLE  | no transaction; pick a winner and ack it
// ST_CMD   | command presented to memory until mem_cmd_ready
// ST_RSP   | read accepted; waiting for mem_rsp_valid or timeout
module mem_bus_arbiter #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32,
  parameter int USB_MAX_WAIT = 8,
  parameter int RSP_TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gba_req,
  input  logic              gba_we,
  input  logic [ADDR_W-1:0] gba_addr,
  input  logic [DATA_W-1:0] gba_wdata,
  output logic              gba_ack,
  output logic              gba_rvalid,
  output logic [DATA_W-1:0] gba_rdata,
  input  logic              usb_req,
  input  logic              usb_we,
  input  logic [ADDR_W-1:0] usb_addr,
  input  logic [DATA_W-1:0] usb_wdata,
  output logic              usb_ack,
  output logic              usb_rvalid,
  output logic [DATA_W-1:0] usb_rdata,
  output logic              rsp_err,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RSP_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  logic [1:0]        state;
  logic              owner_usb;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              idle;
  logic              usb_forced;
  logic              grant_gba;
  logic              grant_usb;
  logic              rsp_done;
  logic [DATA_W-1:0] rsp_word;

  // Acks are gated by rst so nothing is granted while reset is held.
  assign idle      = (state == ST_IDLE) && rst;
  assign grant_gba = idle && gba_req && !usb_forced;
  assign grant_usb = idle && usb_req && (!gba_req || usb_forced);
  assign gba_ack   = grant_gba;
  assign usb_ack   = grant_usb;

  assign mem_cmd_valid = (state == ST_CMD);
  assign busy          = (state != ST_IDLE);

  assign rsp_done = mem_rsp_valid || (tmo_cnt == TMO_LAST);
  assign rsp_word = mem_rsp_valid ? mem_rsp_data : ERR_WORD;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(USB_MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  assign usb_forced = usb_req && (wait_cnt == WAIT_W'(USB_MAX_WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (!usb_req || grant_usb) begin
        wait_cnt <= '0;
      end else if (grant_gba) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end
`else
  // Strict priority build: the wait bound has no effect.
  logic [31:0] unused_max_wait;
  assign unused_max_wait = 32'(USB_MAX_WAIT);
  assign usb_forced = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner_usb  <= 1'b0;
      mem_cmd_we <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      tmo_cnt    <= '0;
      gba_rvalid <= 1'b0;
      usb_rvalid <= 1'b0;
      rsp_err    <= 1'b0;
      gba_rdata  <= '0;
      usb_rdata  <= '0;
    end else begin
      gba_rvalid <= 1'b0;
      usb_rvalid <= 1'b0;
      rsp_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_gba || grant_usb) begin
            owner_usb  <= grant_usb;
            mem_cmd_we <= grant_usb ? usb_we : gba_we;
            mem_addr   <= (grant_usb ? usb_addr : gba_addr) & ADDR_MASK;
            mem_wdata  <= grant_usb ? usb_wdata : gba_wdata;
            state      <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (mem_cmd_ready) begin
            if (mem_cmd_we) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_RSP;
              tmo_cnt <= '0;
            end
          end
        end
        ST_RSP: begin
          if (rsp_done) begin
            if (owner_usb) begin
              usb_rdata  <= rsp_word;
              usb_rvalid <= 1'b1;
            end else begin
              gba_rdata  <= rsp_word;
              gba_rvalid <= 1'b1;
            end
            rsp_err <= !mem_rsp_valid;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int MAXW = 4;
  localparam int TMO = 16;
  localparam logic [31:0] ERRW = 32'hDEADBEEF;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic gba_req, gba_we, gba_ack, gba_rvalid;
  logic [AW-1:0] gba_addr;
  logic [DW-1:0] gba_wdata, gba_rdata;
  logic usb_req, usb_we, usb_ack, usb_rvalid;
  logic [AW-1:0] usb_addr;
  logic [DW-1:0] usb_wdata, usb_rdata;
  logic rsp_err, mem_cmd_valid, mem_cmd_ready, mem_cmd_we, mem_rsp_valid, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rsp_data;

  initial forever #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .USB_MAX_WAIT(MAXW), .RSP_TIMEOUT(TMO), .ERR_WORD(ERRW)
  ) dut (
    .clk(clk), .rst(rst),
    .gba_req(gba_req), .gba_we(gba_we), .gba_addr(gba_addr), .gba_wdata(gba_wdata),
    .gba_ack(gba_ack), .gba_rvalid(gba_rvalid), .gba_rdata(gba_rdata),
    .usb_req(usb_req), .usb_we(usb_we), .usb_addr(usb_addr), .usb_wdata(usb_wdata),
    .usb_ack(usb_ack), .usb_rvalid(usb_rvalid), .usb_rdata(usb_rdata),
    .rsp_err(rsp_err), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // requester shadows, applied at the start of each cycle
  logic s_greq = 0, s_gwe = 0, s_ureq = 0, s_uwe = 0;
  logic [AW-1:0] s_gaddr = '0, s_uaddr = '0;
  logic [DW-1:0] s_gwd = '0, s_uwd = '0;
  bit drop_g = 1, drop_u = 1;
  int rdy_pct = 100, rsp_pct = 0;

  // transaction-level reference model
  logic [31:0] memv [int];
  bit m_busy, m_acc, m_own, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd_exp;
  int m_tcnt, m_wait;
  bit p_rv, p_err, p_own;
  logic [DW-1:0] e_grd, e_urd;

  logic obs_gack, obs_uack, obs_busy, obs_cv, obs_grv, obs_urv, obs_err;
  logic [DW-1:0] obs_grd, obs_urd;

  function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
    int idx;
    idx = int'(a[AW-1:2]);
    if (memv.exists(idx)) return memv[idx];
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_own = 0; m_we = 0; m_tcnt = 0; m_wait = 0;
    p_rv = 0; p_err = 0; p_own = 0; e_grd = '0; e_urd = '0;
    m_addr = '0; m_wd = '0; m_rd_exp = '0;
  endtask

  task automatic tick();
    logic eg, eu, forced, nrv, nerr;
    logic [DW-1:0] ndat;
    @(negedge clk);
    mem_cmd_ready = ($urandom_range(0, 99) < rdy_pct);
    mem_rsp_valid = ($urandom_range(0, 99) < rsp_pct);
    mem_rsp_data  = (m_busy && m_acc) ? mem_rd(m_addr) : $urandom();
    gba_req = s_greq; gba_we = s_gwe; gba_addr = s_gaddr; gba_wdata = s_gwd;
    usb_req = s_ureq; usb_we = s_uwe; usb_addr = s_uaddr; usb_wdata = s_uwd;
    #1;
    forced = GUARD && s_ureq && (m_wait >= MAXW);
    eg = rst && !m_busy && s_greq && !forced;
    eu = rst && !m_busy && s_ureq && (!s_greq || forced);
    obs_gack = gba_ack; obs_uack = usb_ack; obs_busy = busy; obs_cv = mem_cmd_valid;
    obs_grv = gba_rvalid; obs_urv = usb_rvalid; obs_err = rsp_err;
    obs_grd = gba_rdata; obs_urd = usb_rdata;
    chk("gba_ack", gba_ack, eg);
    chk("usb_ack", usb_ack, eu);
    chk("busy", busy, m_busy);
    chk("mem_cmd_valid", mem_cmd_valid, m_busy && !m_acc);
    if (m_busy && !m_acc) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_cmd_we", mem_cmd_we, m_we);
      chk("mem_wdata", mem_wdata, m_wd);
    end
    chk("gba_rvalid", gba_rvalid, p_rv && !p_own);
    chk("usb_rvalid", usb_rvalid, p_rv && p_own);
    chk("rsp_err", rsp_err, p_err);
    chk("gba_rdata", gba_rdata, e_grd);
    chk("usb_rdata", usb_rdata, e_urd);
    nrv = 0; nerr = 0; ndat = '0;
    if (!rst) begin
      model_reset();
    end else if (m_busy && !m_acc) begin
      if (mem_cmd_ready) begin
        if (m_we) begin
          memv[int'(m_addr[AW-1:2])] = m_wd;
          m_busy = 0;
        end else begin
          m_acc = 1;
          m_tcnt = 0;
        end
      end
    end else if (m_busy) begin
      if (mem_rsp_valid) begin
        nrv = 1; ndat = m_rd_exp;
      end else if (m_tcnt == TMO - 1) begin
        nrv = 1; nerr = 1; ndat = ERRW;
      end else begin
        m_tcnt++;
      end
      if (nrv) begin
        m_busy = 0;
        if (m_own) e_urd = ndat; else e_grd = ndat;
      end
    end else begin
      if (!s_ureq) m_wait = 0;
      if (eg || eu) begin
        m_busy = 1; m_acc = 0; m_own = eu;
        m_we   = eu ? s_uwe : s_gwe;
        m_addr = (eu ? s_uaddr : s_gaddr) & ~AW'(3);
        m_wd   = eu ? s_uwd : s_gwd;
        if (!m_we) m_rd_exp = mem_rd(m_addr);
        if (eu) begin
          m_wait = 0;
          if (drop_u) s_ureq = 0;
        end else begin
          if (s_ureq) m_wait++;
          if (drop_g) s_greq = 0;
        end
      end
    end
    if (rst) begin
      p_rv = nrv; p_err = nerr; p_own = m_own;
    end
  endtask

  typedef struct {
    logic greq; logic gwe; logic [AW-1:0] gaddr; logic [DW-1:0] gwd;
    logic ureq; logic uwe; logic [AW-1:0] uaddr; logic [DW-1:0] uwd;
    logic eg; logic eu; logic [AW-1:0] eaddr; logic ewe; logic [DW-1:0] ewd;
  } vec_t;

  initial begin
    vec_t vt [5];
    int first_ack, g_cyc, u_cyc, g_cnt, u_cnt, rsp_cycles, rv, nack;
    logic [DW-1:0] g_dat, u_dat;
    bit done;
    int acks [$];

    vt[0] = '{1'b1, 1'b1, 26'h0000013, 32'h0000A5A5, 1'b0, 1'b0, 26'h0, 32'h0,
              1'b1, 1'b0, 26'h0000010, 1'b1, 32'h0000A5A5};
    vt[1] = '{1'b0, 1'b0, 26'h0, 32'h0, 1'b1, 1'b1, 26'h1000007, 32'h12345678,
              1'b0, 1'b1, 26'h1000004, 1'b1, 32'h12345678};
    vt[2] = '{1'b1, 1'b1, 26'h0000222, 32'h11112222, 1'b1, 1'b1, 26'h0000333, 32'h33334444,
              1'b1, 1'b0, 26'h0000220, 1'b1, 32'h11112222};
    vt[3] = '{1'b0, 1'b1, 26'h7, 32'h5, 1'b0, 1'b1, 26'h9, 32'h6,
              1'b0, 1'b0, 26'h0, 1'b0, 32'h0};
    vt[4] = '{1'b1, 1'b1, 26'h0000002, 32'h0BADF00D, 1'b1, 1'b1, 26'h3FFFFFF, 32'hFFFFFFFF,
              1'b1, 1'b0, 26'h0, 1'b1, 32'h0BADF00D};

    rst = 0;
    gba_req = 0; gba_we = 0; gba_addr = '0; gba_wdata = '0;
    usb_req = 0; usb_we = 0; usb_addr = '0; usb_wdata = '0;
    mem_cmd_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    model_reset();
    tick();
    tick();
    chk("reset_busy", obs_busy, 1'b0);
    chk("reset_cmd_valid", obs_cv, 1'b0);
    chk("reset_gba_rdata", obs_grd, 32'h0);
    rst = 1;
    tick();

    for (int i = 0; i < 5; i++) begin
      s_greq = vt[i].greq; s_gwe = vt[i].gwe; s_gaddr = vt[i].gaddr; s_gwd = vt[i].gwd;
      s_ureq = vt[i].ureq; s_uwe = vt[i].uwe; s_uaddr = vt[i].uaddr; s_uwd = vt[i].uwd;
      tick();
      chk($sformatf("vec%0d_gba_ack", i), obs_gack, vt[i].eg);
      chk($sformatf("vec%0d_usb_ack", i), obs_uack, vt[i].eu);
      s_greq = 0; s_ureq = 0;
      tick();
      chk($sformatf("vec%0d_cmd_valid", i), obs_cv, vt[i].eg | vt[i].eu);
      if (vt[i].eg || vt[i].eu) begin
        chk($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].eaddr);
        chk($sformatf("vec%0d_mem_we", i), mem_cmd_we, vt[i].ewe);
        chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vt[i].ewd);
      end
      tick();
      chk($sformatf("vec%0d_idle_again", i), obs_busy, 1'b0);
    end

    // simultaneous reads: GBA first, each response to its own requester
    memv[16] = 32'hAAAA0000;
    memv[32] = 32'h5555FFFF;
    s_greq = 1; s_gwe = 0; s_gaddr = 26'h41;
    s_ureq = 1; s_uwe = 0; s_uaddr = 26'h80;
    rdy_pct = 100; rsp_pct = 100;
    first_ack = 0; g_cyc = -1; u_cyc = -1; g_cnt = 0; u_cnt = 0; g_dat = '0; u_dat = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (first_ack == 0) begin
        if (obs_gack) first_ack = 1;
        else if (obs_uack) first_ack = 2;
      end
      if (obs_grv) begin g_cnt++; g_dat = obs_grd; g_cyc = c; end
      if (obs_urv) begin u_cnt++; u_dat = obs_urd; u_cyc = c; end
    end
    chk("dual_first_ack_gba", first_ack, 1);
    chk("dual_gba_rvalid_count", g_cnt, 1);
    chk("dual_usb_rvalid_count", u_cnt, 1);
    chk("dual_gba_data", g_dat, 32'hAAAA0000);
    chk("dual_usb_data", u_dat, 32'h5555FFFF);
    chk("dual_usb_after_gba", u_cyc > g_cyc, 1'b1);

    // GBA held continuously against a pending USB write
    s_greq = 0; s_ureq = 0; rsp_pct = 0;
    tick();
    s_greq = 1; s_gwe = 1; s_gaddr = 26'h10; s_gwd = 32'h1; drop_g = 0;
    s_ureq = 1; s_uwe = 1; s_uaddr = 26'h20; s_uwd = 32'h2;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (obs_gack) acks.push_back(1);
      if (obs_uack) acks.push_back(2);
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("guard_enough_grants", acks.size() >= 6, 1'b1);
    if (acks.size() >= 6) begin
      for (int j = 0; j < 4; j++) chk($sformatf("guard_gba_grant%0d", j), acks[j], 1);
      chk("guard_usb_forced", acks[4], 2);
      chk("guard_gba_resumes", acks[5], 1);
    end
`else
    nack = 0;
    foreach (acks[j]) if (acks[j] == 2) nack++;
    chk("strict_no_usb_grant", nack, 0);
    chk("strict_gba_grants", acks.size(), 15);
`endif
    s_greq = 0; drop_g = 1;
    for (int c = 0; c < 4; c++) tick();
    s_ureq = 0;
    tick();

    // read timeout with a dead memory, then a late response that must be ignored
    s_greq = 1; s_gwe = 0; s_gaddr = 26'h200;
    rdy_pct = 100; rsp_pct = 0;
    rsp_cycles = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      if (obs_busy && !obs_cv) rsp_cycles++;
      if (obs_grv) begin
        done = 1;
        chk("tmo_rdata", obs_grd, ERRW);
        chk("tmo_err", obs_err, 1'b1);
      end
    end
    chk("tmo_rvalid_seen", done, 1'b1);
    chk("tmo_rsp_cycles", rsp_cycles, TMO);
    tick();
    chk("tmo_err_one_cycle", obs_err, 1'b0);
    chk("tmo_rvalid_one_cycle", obs_grv, 1'b0);
    rsp_pct = 100; rv = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      rv += int'(obs_grv) + int'(obs_urv);
    end
    chk("late_rsp_ignored", rv, 0);

    // command stalled five cycles by memory
    rsp_pct = 0; rdy_pct = 0;
    s_greq = 1; s_gwe = 1; s_gaddr = 26'h0ABCDEF; s_gwd = 32'hCAFEF00D; drop_g = 0;
    nack = 0;
    tick();
    if (obs_gack) nack++;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (obs_gack) nack++;
      chk($sformatf("stall%0d_valid", c), obs_cv, 1'b1);
      chk($sformatf("stall%0d_addr", c), mem_addr, 26'h0ABCDEC);
      chk($sformatf("stall%0d_wdata", c), mem_wdata, 32'hCAFEF00D);
      chk($sformatf("stall%0d_we", c), mem_cmd_we, 1'b1);
    end
    chk("stall_single_ack", nack, 1);
    s_greq = 0; drop_g = 1; rdy_pct = 100;
    tick();
    tick();
    chk("stall_done_idle", obs_busy, 1'b0);

    // async reset in the middle of a stalled read
    rdy_pct = 0; rsp_pct = 100;
    s_greq = 1; s_gwe = 0; s_gaddr = 26'h100;
    tick();
    chk("rst_pre_ack", obs_gack, 1'b1);
    tick();
    chk("rst_pre_cmd", obs_cv, 1'b1);
    #2;
    gba_req = 1; usb_req = 1;
    rst = 0;
    #1;
    chk("rst_async_cmd_valid", mem_cmd_valid, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_gba_ack", gba_ack, 1'b0);
    chk("rst_async_usb_ack", usb_ack, 1'b0);
    model_reset();
    s_greq = 1; s_ureq = 1;
    tick();
    tick();
    s_greq = 0; s_ureq = 0;
    tick();
    rst = 1;
    rdy_pct = 100; rv = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      rv += int'(obs_grv) + int'(obs_urv);
    end
    chk("rst_no_late_rvalid", rv, 0);

    // randomized traffic against the model
    rdy_pct = 70; rsp_pct = 40;
    for (int c = 0; c < 2000; c++) begin
      if (!s_greq && $urandom_range(0, 99) < 30) begin
        s_greq = 1; s_gwe = 1'($urandom_range(0, 1));
        s_gaddr = AW'($urandom_range(0, 255)); s_gwd = $urandom();
      end else if (s_greq && $urandom_range(0, 99) < 3) begin
        s_greq = 0;
      end
      if (!s_ureq && $urandom_range(0, 99) < 30) begin
        s_ureq = 1; s_uwe = 1'($urandom_range(0, 1));
        s_uaddr = AW'($urandom_range(0, 255)); s_uwd = $urandom();
      end else if (s_ureq && $urandom_range(0, 99) < 3) begin
        s_ureq = 0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
